// File: rtl/vga_scan_counter.sv
// vga_scan_counter: pixel-scan timing generator for the VGA video path.
// Counts horizontal/vertical position on each pixel strobe. It drives the fetch
// coordinates to the address stage one step ahead of the frame-buffer read. It
// also emits sync and visible-area flags, delayed to line up with the read data.
//
// Ports:
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   pix_en      in   pixel strobe; all counting/shifting gated by it
//   x, y        out  fetch column/row (zero outside the visible area)
//   fetch_en    out  (x,y) inside the visible area, undelayed
//   hsync       out  horizontal sync, PIPE_DLY ticks late
//   vsync       out  vertical sync, PIPE_DLY ticks late
//   video_on    out  visible-area flag, PIPE_DLY ticks late
//   frame_start out  one-clk pulse after the strobe that wraps to (0,0)
module vga_scan_counter #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          SYNC_POL = 1'b0,
    parameter int unsigned PIPE_DLY = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pix_en,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       fetch_en,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       frame_start
);

    localparam int unsigned CW       = 10;
    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;

    localparam logic [CW-1:0] H_LAST  = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST  = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_VIS   = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_VIS   = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_LO   = CW'(HS_START);
    localparam logic [CW-1:0] HS_HI   = CW'(HS_END);
    localparam logic [CW-1:0] VS_LO   = CW'(VS_START);
    localparam logic [CW-1:0] VS_HI   = CW'(VS_END);
    localparam logic [PIPE_DLY-1:0] SYNC_IDLE = {PIPE_DLY{~SYNC_POL}};

    logic [CW-1:0]       hc_q, hc_d;
    logic [CW-1:0]       vc_q, vc_d;
    logic [CW-1:0]       x_q, x_d;
    logic [CW-1:0]       y_q, y_d;
    logic                fetch_en_q, fetch_en_d;
    logic                frame_start_q, frame_start_d;
    logic [PIPE_DLY-1:0] hs_pipe_q, hs_pipe_d;
    logic [PIPE_DLY-1:0] vs_pipe_q, vs_pipe_d;
    logic [PIPE_DLY-1:0] vo_pipe_q, vo_pipe_d;
    logic                hs_raw;
    logic                vs_raw;
    logic                vis;

    // Next-state: counters, fetch coordinates and delay lines advance on pix_en only.
    always_comb begin
        hc_d          = hc_q;
        vc_d          = vc_q;
        x_d           = x_q;
        y_d           = y_q;
        fetch_en_d    = fetch_en_q;
        frame_start_d = 1'b0;
        hs_pipe_d     = hs_pipe_q;
        vs_pipe_d     = vs_pipe_q;
        vo_pipe_d     = vo_pipe_q;
        vis           = 1'b0;

        // Raw sync decoded from the current count, so it stays aligned with fetch_en_q.
        hs_raw = ((hc_q >= HS_LO) && (hc_q < HS_HI)) ? SYNC_POL : ~SYNC_POL;
        vs_raw = ((vc_q >= VS_LO) && (vc_q < VS_HI)) ? SYNC_POL : ~SYNC_POL;

        if (pix_en) begin
            if (hc_q == H_LAST) begin
                hc_d = '0;
                if (vc_q == V_LAST) begin
                    vc_d          = '0;
                    frame_start_d = 1'b1;
                end else begin
                    vc_d = vc_q + CW'(1);
                end
            end else begin
                hc_d = hc_q + CW'(1);
            end

            // Fetch outputs follow the next count so they move on the same edge.
            vis        = (hc_d < H_VIS) && (vc_d < V_VIS);
            fetch_en_d = vis;
            x_d        = vis ? hc_d : '0;
            y_d        = vis ? vc_d : '0;

            hs_pipe_d[0] = hs_raw;
            vs_pipe_d[0] = vs_raw;
            vo_pipe_d[0] = fetch_en_q;
            for (int i = 1; i < int'(PIPE_DLY); i++) begin
                hs_pipe_d[i] = hs_pipe_q[i-1];
                vs_pipe_d[i] = vs_pipe_q[i-1];
                vo_pipe_d[i] = vo_pipe_q[i-1];
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hc_q          <= '0;
            vc_q          <= '0;
            x_q           <= '0;
            y_q           <= '0;
            fetch_en_q    <= 1'b0;
            frame_start_q <= 1'b0;
            hs_pipe_q     <= SYNC_IDLE;
            vs_pipe_q     <= SYNC_IDLE;
            vo_pipe_q     <= '0;
        end else begin
            hc_q          <= hc_d;
            vc_q          <= vc_d;
            x_q           <= x_d;
            y_q           <= y_d;
            fetch_en_q    <= fetch_en_d;
            frame_start_q <= frame_start_d;
            hs_pipe_q     <= hs_pipe_d;
            vs_pipe_q     <= vs_pipe_d;
            vo_pipe_q     <= vo_pipe_d;
        end
    end

    assign x           = x_q;
    assign y           = y_q;
    assign fetch_en    = fetch_en_q;
    assign frame_start = frame_start_q;
    assign hsync       = hs_pipe_q[PIPE_DLY-1];
    assign vsync       = vs_pipe_q[PIPE_DLY-1];
    assign video_on    = vo_pipe_q[PIPE_DLY-1];

endmodule
